// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin arbiter that serialises NUM_REQ requesters onto the SPI RAM two-frame command port
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_i            per-requester level request
//   req_we_i         per-requester op, 1 = write, 0 = read
//   req_addr_i       packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
//   req_wdata_i      packed write data, requester i at [i*MEM_WIDTH +: MEM_WIDTH]
//   ack_o            one-hot single-cycle completion pulse
//   rdata_o          read data, valid with ack_o
//   rd_err_o         read timeout flag, valid with ack_o
//   busy_o           high whenever a transaction is in flight
//   rx_data_o        RAM frame, control code in the top two bits
//   rx_valid_o       RAM frame valid
//   tx_valid_i       RAM read data valid
//   dout_i           RAM read data
// Optional: define SPI_ARB_ADDR_SKIP_EN to skip the address frame when it repeats the last one sent for that op.
module spi_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             req_we_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr_i,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [MEM_WIDTH-1:0]           rdata_o,
  output logic                           rd_err_o,
  output logic                           busy_o,
  output logic [MEM_WIDTH+1:0]           rx_data_o,
  output logic                           rx_valid_o,
  input  logic                           tx_valid_i,
  input  logic [MEM_WIDTH-1:0]           dout_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [1:0] WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, ACK} state_t;
  state_t                 state_q;
  logic [IW-1:0]          ptr_q, win_q, win;
  logic                   we_q;
  logic [MEM_WIDTH-1:0]   wdata_q, rdata_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic                   rd_err_q, busy_q, rx_valid_q;
  logic [MEM_WIDTH+1:0]   rx_data_q;
  logic [IW:0]            t;
  logic                   g_we;
  logic [ADDR_SIZE-1:0]   g_addr;
  logic [MEM_WIDTH-1:0]   g_wdata;
  logic [MEM_WIDTH+1:0]   a_frame;
  // Scan from the farthest candidate to the nearest so the first set bit after ptr_q is the last one written.
  always_comb begin
    win = ptr_q;
    t = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      t = {1'b0, ptr_q} + (IW+1)'(k);
      t = t >= (IW+1)'(NUM_REQ) ? t - (IW+1)'(NUM_REQ) : t;
      win = req_i[t[IW-1:0]] ? t[IW-1:0] : win;
    end
  end
  assign g_we    = req_we_i[win];
  assign g_addr  = req_addr_i[win*ADDR_SIZE +: ADDR_SIZE];
  assign g_wdata = req_wdata_i[win*MEM_WIDTH +: MEM_WIDTH];
  assign a_frame = {g_we ? WR_ADDR : RD_ADDR, MEM_WIDTH'(g_addr)};
`ifdef SPI_ARB_ADDR_SKIP_EN
  logic [ADDR_SIZE-1:0] lwa_q, lra_q;
  logic                 lwv_q, lrv_q, hit;
  assign hit = g_we ? (lwv_q && lwa_q == g_addr) : (lrv_q && lra_q == g_addr);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      win_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rd_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef SPI_ARB_ADDR_SKIP_EN
      lwa_q      <= '0;
      lra_q      <= '0;
      lwv_q      <= 1'b0;
      lrv_q      <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: if (|req_i) begin
          win_q      <= win;
          ptr_q      <= win;
          we_q       <= g_we;
          wdata_q    <= g_wdata;
          rdata_q    <= '0;
          rd_err_q   <= 1'b0;
          busy_q     <= 1'b1;
          rx_valid_q <= 1'b1;
`ifdef SPI_ARB_ADDR_SKIP_EN
          if (hit) begin
            state_q   <= DATA;
            rx_data_q <= g_we ? {WR_DATA, g_wdata} : {RD_DATA, {MEM_WIDTH{1'b0}}};
          end else begin
            state_q   <= ADDR;
            rx_data_q <= a_frame;
            if (g_we) begin
              lwa_q <= g_addr;
              lwv_q <= 1'b1;
            end else begin
              lra_q <= g_addr;
              lrv_q <= 1'b1;
            end
          end
`else
          state_q   <= ADDR;
          rx_data_q <= a_frame;
`endif
        end
        ADDR: begin
          rx_data_q <= we_q ? {WR_DATA, wdata_q} : {RD_DATA, {MEM_WIDTH{1'b0}}};
          state_q   <= DATA;
        end
        DATA: begin
          rx_valid_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= we_q ? ACK : WAIT;
          if (we_q) ack_q[win_q] <= 1'b1;
        end
        WAIT: begin
          if (tx_valid_i) begin
            rdata_q       <= dout_i;
            rd_err_q      <= 1'b0;
            ack_q[win_q]  <= 1'b1;
            state_q       <= ACK;
          end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
            rdata_q       <= '0;
            rd_err_q      <= 1'b1;
            ack_q[win_q]  <= 1'b1;
            state_q       <= ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack_o      = ack_q;
  assign rdata_o    = rdata_q;
  assign rd_err_o   = rd_err_q;
  assign busy_o     = busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: scoreboard bench with a behavioural SPI RAM for spi_ram_arbiter
module tb_spi_ram_arbiter;
  localparam int N = 2, MW = 8, AS = 8, TO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0, req_we = '0;
  logic [N*AS-1:0] req_addr = '0;
  logic [N*MW-1:0] req_wdata = '0;
  logic [N-1:0] ack;
  logic [MW-1:0] rdata;
  logic rd_err, busy;
  logic [MW+1:0] rx_data;
  logic rx_valid;
  logic tx_valid = 1'b0;
  logic [MW-1:0] dout = '0;
  int checks = 0, errors = 0;
  bit mon_en = 1'b0, tx_en = 1'b1;
  typedef struct {int idx; bit we; logic [MW-1:0] rd; logic err;} rec_t;
  logic [MW+1:0] fq[$];
  rec_t aq[$];
  rec_t r;
  logic [7:0] mem [256];
  logic [7:0] wa = '0, ra = '0;
  always #5 clk = ~clk;
  spi_ram_arbiter #(.NUM_REQ(N), .MEM_WIDTH(MW), .ADDR_SIZE(AS), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .ack_o(ack), .rdata_o(rdata), .rd_err_o(rd_err), .busy_o(busy),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .tx_valid_i(tx_valid), .dout_i(dout)
  );
  // Behavioural RAM: answers one cycle after the RD_DATA frame unless tx_en is cleared.
  always @(posedge clk) begin
    tx_valid <= 1'b0;
    if (rx_valid)
      case (rx_data[9:8])
        2'b00: wa <= rx_data[7:0];
        2'b01: mem[wa] <= rx_data[7:0];
        2'b10: ra <= rx_data[7:0];
        default: if (tx_en) begin
          tx_valid <= 1'b1;
          dout <= mem[ra];
        end
      endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (rx_valid) begin
      if (fq.size() == 0) chk("frame_extra", 32'(fq.size()), 32'd1);
      else chk("frame", 32'(rx_data), 32'(fq.pop_front()));
    end
    if (|ack) begin
      chk("ack_onehot", 32'($countones(ack)), 32'd1);
      if (aq.size() == 0) chk("ack_extra", 32'(aq.size()), 32'd1);
      else begin
        r = aq.pop_front();
        chk("ack_idx", 32'(ack), 32'd1 << r.idx);
        if (!r.we) begin
          chk("rdata", 32'(rdata), 32'(r.rd));
          chk("rd_err", 32'(rd_err), 32'(r.err));
        end
      end
    end
  end
  task automatic setup(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    req_we[i] = we;
    req_addr[i*AS +: AS] = a;
    req_wdata[i*MW +: MW] = d;
  endtask
  task automatic expect_txn(input int i, input bit we, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] rd, input bit err, input bit skip);
    if (!skip) fq.push_back({we ? 2'b00 : 2'b10, a});
    fq.push_back(we ? {2'b01, d} : {2'b11, 8'h00});
    aq.push_back('{i, we, rd, err});
  endtask
  task automatic txn(input int i, input bit we, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] rd, input bit err, input int lat, input bit skip, input bit drop);
    int n;
    setup(i, we, a, d);
    expect_txn(i, we, a, d, rd, err, skip);
    req[i] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1 n++;
      if (drop && n == 1) req[i] = 1'b0;
    end while (!ack[i] && n < 60);
    req[i] = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("busy_at_ack", 32'(busy), 32'd1);
    @(posedge clk); #1 chk("idle_after", 32'(busy), 32'd0);
  endtask
  task automatic rr(input int cnt);
    int k, n;
    setup(0, 1'b1, 8'h20, 8'h11);
    setup(1, 1'b1, 8'h21, 8'h22);
    for (int j = 0; j < cnt; j++)
      expect_txn(j % 2, 1'b1, j % 2 ? 8'h21 : 8'h20, j % 2 ? 8'h22 : 8'h11, 8'h00, 1'b0, 1'b0);
    req = 2'b11;
    k = 0;
    n = 0;
    while (k < cnt && n < 100) begin
      @(posedge clk); #1 n++;
      if (|ack) k++;
    end
    req = '0;
    chk("rr_acks", 32'(k), 32'(cnt));
    chk("rr_cycles", 32'(n), 32'(4 * cnt - 1));
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    bit seen;
    #12;
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    txn(0, 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, 3, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h40, 8'h3C, 8'h00, 1'b0, 3, 1'b0, 1'b0);
    txn(1, 1'b0, 8'h40, 8'h00, 8'h3C, 1'b0, 4, 1'b0, 1'b0);
    rr(4);
    tx_en = 1'b0;
    txn(1, 1'b0, 8'h41, 8'h00, 8'h00, 1'b1, 3 + TO, 1'b0, 1'b0);
    tx_en = 1'b1;
    txn(0, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 4, 1'b0, 1'b1);
    mon_en = 1'b0;
    setup(0, 1'b1, 8'h77, 8'h99);
    req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_data", 32'(rx_data), 32'h199);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rx_valid", 32'(rx_valid), 32'd0);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    req = '0;
    seen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1 seen |= |ack;
    end
    chk("no_ack_after_rst", 32'(seen), 32'd0);
    fq.delete();
    aq.delete();
    mon_en = 1'b1;
    rr(2);
`ifdef SPI_ARB_ADDR_SKIP_EN
    txn(0, 1'b1, 8'h55, 8'hAA, 8'h00, 1'b0, 3, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h55, 8'hBB, 8'h00, 1'b0, 2, 1'b1, 1'b0);
    txn(0, 1'b1, 8'h56, 8'hCC, 8'h00, 1'b0, 3, 1'b0, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("frames_left", 32'(fq.size()), 32'd0);
    chk("acks_left", 32'(aq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single SPI RAM command port (rx_data/rx_valid in, dout/tx_valid out) among NUM_REQ local requesters.
- Converts each granted request (op, addr, wdata) into the RAM's two-frame protocol: address frame, then data frame.
- For reads, waits for tx_valid, returns dout, and flags a timeout if the read never returns.
- Sits between the local host ports and the RAM, in parallel with the SPI slave path used by the system bench.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MEM_WIDTH, 8, RAM data width
ADDR_SIZE, 8, RAM address width (must be <= MEM_WIDTH)
RD_TIMEOUT, 15, max cycles in WAIT before a read error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, level
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
req_wdata  in  NUM_REQ*MEM_WIDTH  packed write data
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
rdata  out  MEM_WIDTH  read data, valid with ack
rd_err  out  1  read timeout flag, valid with ack
busy  out  1  high when not in IDLE
rx_data  out  MEM_WIDTH+2  RAM frame, control bits in [MEM_WIDTH+1:MEM_WIDTH]
rx_valid  out  1  RAM frame valid
tx_valid  in  1  RAM read-data valid
dout  in  MEM_WIDTH  RAM read data

Behaviour:
- Reset: rst_n is asynchronous and active-low on clk.
  - All outputs 0; state = IDLE.
  - RR pointer = NUM_REQ-1, so req[0] wins first.
  - Timeout counter 0.
- Control encoding: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11. Address is zero-extended into the low MEM_WIDTH bits.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, WAIT, ACK.
- IDLE:
  - If any req is high, pick the first set bit searching from ptr+1 with wrap.
  - Latch winner index, we, addr and wdata; set ptr = winner; go to ADDR.
  - Fields are latched at grant; later input changes are ignored.
- ADDR (1 cycle): rx_valid=1, rx_data={we?WR_ADDR:RD_ADDR, addr}. Go to DATA.
- DATA (1 cycle):
  - Write: rx_valid=1, rx_data={WR_DATA, wdata}; go to ACK.
  - Read: rx_valid=1, rx_data={RD_DATA, 0}; go to WAIT.
- WAIT:
  - rx_valid=0.
  - If tx_valid: capture dout, rd_err=0, go to ACK.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT: rdata=0, rd_err=1, go to ACK.
  - The counter clears on entry.
- ACK (1 cycle): ack[winner]=1, rdata/rd_err held. Go to IDLE.
- Latency from the IDLE sample cycle of req: write ack at cycle 3; read ack at cycle 4 with a RAM that answers 1 cycle after RD_DATA.
- Requester handshake:
  - Requester must drop req in the cycle after ack, otherwise it is re-arbitrated.
  - Because the pointer has moved, a competing requester wins first.
  - Dropping req before ack does not abort; ack still pulses.
- Simultaneous requests: strict round-robin, no starvation. Each requester is granted within NUM_REQ transactions.
- tx_valid outside WAIT is ignored.
- Reset mid-transaction: abort immediately; no ack is issued, rx_valid=0.

Optional Feature:
- Macro: SPI_ARB_ADDR_SKIP_EN.
- Defined:
  - Track last_wr_addr/last_rd_addr, each with a valid bit (cleared on reset).
  - If the granted op's addr equals the matching last address and valid=1, IDLE goes directly to DATA, skipping ADDR. Write ack then arrives at cycle 2.
  - Every issued ADDR frame updates the tracker.
- Undefined: the ADDR frame is always sent; no tracker logic.

Test Plan:
- Reset then req[0] write addr=0x12, wdata=0xA5 -> rx_data 0x012 then 0x1A5, rx_valid high 2 cycles, ack[0] at cycle 3, busy high cycles 1-3.
- Write 0x3C->0x40 then read 0x40 via req[1] -> frames 0x240, 0x300, tx_valid, ack[1] at cycle 4 with rdata=0x3C, rd_err=0.
- req=2'b11 held continuously, all writes -> grants alternate 0,1,0,1; ack is never two-hot.
- Read with tx_valid forced 0 -> ack after RD_TIMEOUT (15) WAIT cycles, rdata=0x00, rd_err=1, then return to IDLE.
- rst_n asserted during DATA of a write -> outputs 0 asynchronously, no ack. After release, req[0] wins the first grant.
- SPI_ARB_ADDR_SKIP_EN: two writes to 0x55 -> second transaction sends only 0x1xx frame, ack at cycle 2. Write to 0x56 -> ADDR frame resent.
